square_osc: RTL and testbench
=============================

// Module: square_osc
// PURPOSE
//   Tone-generator stage directly downstream of the note-to-count converter. Consumes the
//   registered half-period count and produces a 50%-duty square wave with a note gate.
//   Period changes take effect only at half-period boundaries, so the output never glitches.
//   Gate release lets the current high half complete before silence, so no runt pulses.
// PARAMETERS
//   BW        16  width of halfCntPeriod_i and the internal half-period counter
//   PRESCALE  1   clock enables per counter tick (>=1); 1 = count every clk_i cycle
// PORTS
//   clk_i            in   1   system clock
//   rst_i            in   1   synchronous active-high reset
//   halfCntPeriod_i  in   BW  half-period length in ticks; 0 = silent
//   gate_i           in   1   note on (1) / note off (0), level-sensitive
//   wave_o           out  1   square-wave output, registered
//   edge_o           out  1   1-cycle pulse in the cycle wave_o changes value
//   active_o         out  1   1 while state != IDLE
// BEHAVIOUR
//   - Reset: rst_i=1 at posedge -> wave_o=0, edge_o=0, active_o=0, state=IDLE, cnt=0,
//     perReg=0, prescaler=0. Reset takes priority over all events, including mid-note.
//   - Tick: the prescaler counts 0..PRESCALE-1; tick=1 when it equals PRESCALE-1.
//     With PRESCALE=1, tick=1 every cycle. The prescaler is cleared on the IDLE->RUN start.
//   - Boundary: tick && cnt==perReg-1. At a boundary: cnt<=0, wave_o toggles, edge_o<=1,
//     and perReg<=halfCntPeriod_i (resampled). Otherwise, on tick: cnt<=cnt+1.
//   - IDLE: wave_o=0. If gate_i=1 and halfCntPeriod_i!=0: perReg<=halfCntPeriod_i,
//     cnt<=0, wave_o<=1, edge_o<=1, state<=RUN. Latency is 1 cycle from gate sample
//     to wave_o high. If gate_i=1 and halfCntPeriod_i=0: stay in IDLE.
//   - RUN: counts normally. If gate_i=0:
//       wave_o=1 -> DRAIN;
//       wave_o=0 -> IDLE next cycle, with no edge_o pulse.
//   - DRAIN: counts normally. If gate_i=1 again: back to RUN with the phase unchanged.
//     At the boundary: wave_o<=0, edge_o<=1, state<=IDLE, active_o drops in the same cycle.
//   - Resampled period 0 at a boundary: wave_o<=0, state<=IDLE. edge_o pulses only if
//     wave_o was 1.
//   - Timing: each half lasts exactly perReg*PRESCALE clocks; full period is 2*perReg*PRESCALE.
//     A new halfCntPeriod_i never shortens or extends the half already in progress.
//   - Simultaneous events: gate fall together with a boundary -> the boundary is processed
//     first, then the gate rule is evaluated against the new wave_o. A fall to 0 goes to IDLE.
//   - Widths: cnt and perReg are BW bits; perReg-1 is evaluated only when perReg!=0.
// STRUCTURE
//   - global.v: OSC_CNT_BW define, and the state encodings OSC_IDLE=2'd0, OSC_RUN=2'd1,
//     OSC_DRAIN=2'd2.
//   - Sub-module tick_prescaler (params PRESCALE; ports clk_i, rst_i, clr_i, tick_o).
//   - Top level: one 2-bit FSM register, a counter with compare, and registered outputs.
// TESTING
//   1 PRESCALE=1, period=4, gate 0->1 at cyc0 -> wave_o high cyc1-4, low cyc5-8,
//     edge_o pulses at cyc1,5,9; active_o=1 from cyc1.
//   2 Period changes 4->6 at cyc2 (high half) -> high stays 4 cycles, the next low half
//     lasts 6 cycles.
//   3 Gate drops at cyc2 (high half, period 4) -> wave_o falls at cyc5, active_o=0 at cyc5,
//     wave_o stays 0 afterwards. Gate drops in a low half -> active_o=0 next cycle,
//     no edge_o pulse.
//   4 Gate=1 with period=0 -> stays IDLE, all outputs 0. Period goes to 0 mid-RUN ->
//     stops at the next boundary with wave_o=0.
//   5 PRESCALE=3, period=2 -> each half lasts 6 clocks; edge_o pulses spaced 6 cycles apart.
//   6 rst_i=1 for one cycle mid-high half -> all outputs 0 the next cycle; with gate held
//     high, restarts 1 cycle after rst_i falls.

Source files
------------

// File: rtl/square_osc_pkg.sv
// Shared types and defaults for the square-wave tone oscillator.
package square_osc_pkg;

   localparam int OSC_CNT_BW = 16;

   typedef enum logic [1:0] {
      OSC_IDLE  = 2'd0,
      OSC_RUN   = 2'd1,
      OSC_DRAIN = 2'd2
   } osc_state_e;

endpackage

// File: rtl/square_osc_if.sv
// Note/period request in, square wave and status out.
interface square_osc_if
   import square_osc_pkg::*;
#(
   parameter int BW = OSC_CNT_BW
);
   logic [BW-1:0] halfCntPeriod_i;
   logic          gate_i;
   logic          wave_o;
   logic          edge_o;
   logic          active_o;

   modport master (
      output halfCntPeriod_i, gate_i,
      input  wave_o, edge_o, active_o
   );

   modport slave (
      input  halfCntPeriod_i, gate_i,
      output wave_o, edge_o, active_o
   );
endinterface

// File: rtl/square_osc_tick_prescaler.sv
// Divides clk_i into counter ticks; one tick every PRESCALE cycles.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);
   localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q;

   // Wrapping 0..PRESCALE-1 counter; clr realigns the phase to a note start.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + PW'(1);
      end
   end

   assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/square_osc.sv
// 50%-duty square-wave oscillator with glitch-free period changes and gate drain.
module square_osc
   import square_osc_pkg::*;
#(
   parameter int BW       = OSC_CNT_BW,
   parameter int PRESCALE = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   square_osc_if.slave osc
);
   osc_state_e    state_q, state_nx;
   logic [BW-1:0] cnt_q, cnt_nx;
   logic [BW-1:0] per_q, per_nx;
   logic          wave_q, wave_nx;
   logic          edge_q, edge_nx;
   logic          tick;
   logic          start;
   logic          boundary;
   logic          per_zero;

   tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (start),
      .tick_o (tick)
   );

   assign per_zero = (osc.halfCntPeriod_i == '0);
   // perReg is never 0 outside IDLE, the guard only keeps perReg-1 from wrapping.
   assign boundary = tick && (per_q != '0) && (cnt_q == per_q - BW'(1));

   // State, counter, period latch and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= OSC_IDLE;
         cnt_q   <= '0;
         per_q   <= '0;
         wave_q  <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         state_q <= state_nx;
         cnt_q   <= cnt_nx;
         per_q   <= per_nx;
         wave_q  <= wave_nx;
         edge_q  <= edge_nx;
      end
   end

   // Next state: boundary work first, then the gate is judged against the new wave level.
   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      per_nx   = per_q;
      wave_nx  = wave_q;
      edge_nx  = 1'b0;
      start    = 1'b0;
      case (state_q)
         OSC_IDLE: begin
            wave_nx = 1'b0;
            if (osc.gate_i && !per_zero) begin
               start    = 1'b1;
               per_nx   = osc.halfCntPeriod_i;
               cnt_nx   = '0;
               wave_nx  = 1'b1;
               edge_nx  = 1'b1;
               state_nx = OSC_RUN;
            end
         end
         default: begin
            // RUN and DRAIN count identically; DRAIN only differs in why it is held.
            if (boundary) begin
               cnt_nx = '0;
               per_nx = osc.halfCntPeriod_i;
               if (per_zero) begin
                  wave_nx = 1'b0;
                  edge_nx = wave_q;
               end else begin
                  wave_nx = ~wave_q;
                  edge_nx = 1'b1;
               end
            end else if (tick) begin
               cnt_nx = cnt_q + BW'(1);
            end
            if (boundary && per_zero) begin
               state_nx = OSC_IDLE;
            end else if (osc.gate_i) begin
               state_nx = OSC_RUN;
            end else if (wave_nx) begin
               state_nx = OSC_DRAIN;
            end else begin
               state_nx = OSC_IDLE;
            end
         end
      endcase
   end

   assign osc.wave_o   = wave_q;
   assign osc.edge_o   = edge_q;
   assign osc.active_o = (state_q != OSC_IDLE);
endmodule

// File: tb/tb_square_osc.sv
// Bench for square_osc: directed waveform checks plus randomized run against a timing model.
module tb_square_osc;
   import square_osc_pkg::*;

   localparam int BW = 16;

   typedef struct {
      bit act;
      bit wave;
      bit edg;
      int left;
   } mstate_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          gate;
   logic [BW-1:0] per;

   int vectors     = 0;
   int miscompares = 0;
   int ps[2]       = '{1, 3};
   mstate_t m[2];

   square_osc_if #(.BW(BW)) if0 ();
   square_osc_if #(.BW(BW)) if1 ();

   assign if0.gate_i          = gate;
   assign if0.halfCntPeriod_i = per;
   assign if1.gate_i          = gate;
   assign if1.halfCntPeriod_i = per;

   square_osc #(.BW(BW), .PRESCALE(1)) dut0 (.clk_i(clk), .rst_i(rst), .osc(if0));
   square_osc #(.BW(BW), .PRESCALE(3)) dut1 (.clk_i(clk), .rst_i(rst), .osc(if1));

   always #5 clk = ~clk;

   // Model: a note is a run of halves, each lasting period*prescale clocks.
   function automatic mstate_t step(input mstate_t s, input int p);
      mstate_t n;
      n     = s;
      n.edg = 1'b0;
      if (rst) begin
         n.act = 1'b0; n.wave = 1'b0; n.left = 0;
      end else if (!s.act) begin
         n.wave = 1'b0;
         if (gate && per != 0) begin
            n.act = 1'b1; n.wave = 1'b1; n.edg = 1'b1; n.left = int'(per) * p;
         end
      end else begin
         n.left = s.left - 1;
         if (n.left == 0) begin
            if (per == 0) begin
               n.edg = s.wave; n.wave = 1'b0; n.act = 1'b0;
            end else begin
               n.wave = !s.wave; n.edg = 1'b1; n.left = int'(per) * p;
            end
         end
         if (n.act && !gate && !n.wave) n.act = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) m[i] <= step(m[i], ps[i]);
   end

   function automatic logic [2:0] dut_out(input int i);
      if (i == 0) return {if0.wave_o, if0.edge_o, if0.active_o};
      return {if1.wave_o, if1.edge_o, if1.active_o};
   endfunction

   // One cycle: wait to mid-cycle, check both DUTs against the model, optionally a literal.
   task automatic tick_check(input int ld, input string nm, input string ew, input string ee,
                             input string ea, input int c);
      logic [2:0] got, exp;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         got = dut_out(i);
         exp = {m[i].wave, m[i].edg, m[i].act};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL model dut%0d t=%0t wave/edge/active got=%b exp=%b", i, $time, got, exp);
         end
      end
      if (ld >= 0) begin
         got = dut_out(ld);
         exp = {ew[c] == 8'h31, ee[c] == 8'h31, ea[c] == 8'h31};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc%0d dut%0d wave/edge/active got=%b exp=%b", nm, c + 1, ld, got, exp);
         end
      end
   endtask

   // kind: 0 none, 1 period:=val, 2 gate:=val, 3 one-cycle reset pulse; all at cycle cc.
   task automatic scenario(input string nm, input int ld, input int p0, input int cc,
                           input int kind, input int val,
                           input string ew, input string ee, input string ea);
      rst = 1'b1; gate = 1'b0; per = '0;
      tick_check(-1, nm, "", "", "", 0);
      tick_check(-1, nm, "", "", "", 0);
      rst = 1'b0;
      tick_check(-1, nm, "", "", "", 0);
      gate = 1'b1; per = BW'(p0);
      for (int c = 1; c <= ew.len(); c++) begin
         tick_check(ld, nm, ew, ee, ea, c - 1);
         if (c == cc) begin
            case (kind)
               1: per  = BW'(val);
               2: gate = val[0];
               3: rst  = 1'b1;
               default: ;
            endcase
         end
         if (kind == 3 && c == cc + 1) rst = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; gate = 1'b0; per = '0;
      for (int i = 0; i < 2; i++) m[i] = '{act: 1'b0, wave: 1'b0, edg: 1'b0, left: 0};
      tick_check(0, "reset", "0", "0", "0", 0);
      tick_check(1, "reset", "0", "0", "0", 0);

      //        name        dut per cc kind val  wave              edge              active
      scenario("basic",      0, 4,  0, 0, 0, "1111000011",       "1000100010",     "1111111111");
      scenario("per4to6",    0, 4,  2, 1, 6, "11110000001111",   "10001000001000", "11111111111111");
      scenario("drain_hi",   0, 4,  2, 2, 0, "11110000",         "10001000",       "11110000");
      scenario("drop_lo",    0, 4,  6, 2, 0, "1111000000",       "1000100000",     "1111110000");
      scenario("per0_idle",  0, 0,  0, 0, 0, "00000",            "00000",          "00000");
      scenario("per0_hi",    0, 4,  2, 1, 0, "11110000",         "10001000",       "11110000");
      scenario("per0_lo",    0, 4,  6, 1, 0, "1111000000",       "1000100000",     "1111111100");
      scenario("prescale3",  1, 2,  0, 0, 0, "11111100000011",   "10000010000010", "11111111111111");
      scenario("reset_mid",  0, 4,  2, 3, 0, "1101111000",       "1001000100",     "1101111111");

      // Randomized run: gate toggles, period retargets, rare resets, all checked by the model.
      rst = 1'b0; gate = 1'b1; per = BW'(3);
      for (int n = 0; n < 4000; n++) begin
         tick_check(-1, "rand", "", "", "", 0);
         rst = 1'b0;
         if ($urandom_range(0, 19) == 0) gate = ~gate;
         if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 5))
               0: per = '0;
               1: per = BW'(1);
               2: per = BW'(2);
               3: per = BW'(3);
               4: per = BW'($urandom_range(4, 12));
               default: per = BW'($urandom_range(1, 40));
            endcase
         end
         if ($urandom_range(0, 299) == 0) rst = 1'b1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
